align_shf74: RTL and testbench

//  Addend alignment shifter for the single-precision fused multiply-add datapath.
//  - Places the 24-bit addend significand (hidden bit included) at the top of a 98-bit field.
//  - Shifts it right by the exponent-difference amount.
//  - Optionally one's-complements the field for effective subtraction.
//  - Sits between exponent-difference logic and the 3:2 compressor / adder stage.
//  - Output is registered: one pipeline stage.

---
 rtl/align_shf74.sv | 56 +++++
 tb/tb_align_shf74.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/align_shf74.sv
// align_shf74: addend alignment shifter for the single-precision FMA datapath.
//
// The 24-bit addend significand (hidden bit included) is placed at the top of a
// 98-bit field and shifted right by the clamped exponent difference. For
// effective subtraction the field is then one's-complemented. One register
// stage follows.
//
// Ports:
//   clk       in   1   clock, rising-edge
//   rst_n     in   1   asynchronous active-low reset (clears shf_res)
//   inv_mask  in   1   1 = one's-complement the aligned field
//   c_frac    in   24  addend significand, bit 23 = hidden bit
//   shf_num   in   7   right-shift amount, values above 74 clamp to 74
//   shf_res   out  98  registered aligned (optionally inverted) addend
module align_shf74 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inv_mask,
  input  logic [23:0] c_frac,
  input  logic [6:0]  shf_num,
  output logic [97:0] shf_res
);

  localparam logic [6:0] MaxShf = 7'd74;

  logic [6:0]  shf_eff;
  logic [97:0] lvl0, lvl1, lvl2, lvl3, lvl4, lvl5, lvl6, lvl7;
  logic [97:0] shf_res_d;

  // Upstream owns sticky collection, so the shift never pushes c_frac out entirely.
  assign shf_eff = (shf_num > MaxShf) ? MaxShf : shf_num;

  // Seven-level logarithmic barrel shifter, one level per bit of shf_eff.
  always_comb begin
    lvl0 = {c_frac, 74'b0};
    lvl1 = shf_eff[0] ? (lvl0 >> 1)  : lvl0;
    lvl2 = shf_eff[1] ? (lvl1 >> 2)  : lvl1;
    lvl3 = shf_eff[2] ? (lvl2 >> 4)  : lvl2;
    lvl4 = shf_eff[3] ? (lvl3 >> 8)  : lvl3;
    lvl5 = shf_eff[4] ? (lvl4 >> 16) : lvl4;
    lvl6 = shf_eff[5] ? (lvl5 >> 32) : lvl5;
    lvl7 = shf_eff[6] ? (lvl6 >> 64) : lvl6;
  end

  // Inversion covers the zero-filled positions too; they become ones.
  assign shf_res_d = inv_mask ? ~lvl7 : lvl7;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shf_res <= '0;
    end else begin
      shf_res <= shf_res_d;
    end
  end

endmodule

// File: tb/tb_align_shf74.sv
// Testbench for align_shf74: a bench-side reference model checked every cycle,
// plus hand-computed literal vectors, a full shift sweep and an async reset test.
module tb_align_shf74;

  logic        clk;
  logic        rst_n;
  logic        inv_mask;
  logic [23:0] c_frac;
  logic [6:0]  shf_num;
  logic [97:0] shf_res;

  int checks = 0;
  int errors = 0;
  logic        cmp_en = 1'b0;
  logic [97:0] exp_q;

  align_shf74 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .inv_mask (inv_mask),
    .c_frac   (c_frac),
    .shf_num  (shf_num),
    .shf_res  (shf_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: significand at the top of 98 bits, shifted right, optionally inverted.
  function automatic logic [97:0] model(input logic inv, input logic [23:0] f,
                                        input int unsigned s);
    int unsigned e;
    logic [97:0] a;
    e = (s > 74) ? 74 : s;
    a = {f, 74'b0};
    a = a >> e;
    return inv ? ~a : a;
  endfunction

  // Expected register content, one cycle behind the inputs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_q <= '0;
    else        exp_q <= model(inv_mask, c_frac, int'(shf_num));
  end

  task automatic check(input string name, input logic [97:0] act, input logic [97:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) check("model", shf_res, exp_q);
  end

  task automatic apply(input logic inv, input logic [23:0] f, input logic [6:0] s);
    @(negedge clk);
    inv_mask = inv;
    c_frac   = f;
    shf_num  = s;
  endtask

  task automatic apply_check(input string name, input logic inv, input logic [23:0] f,
                             input logic [6:0] s, input logic [97:0] req);
    apply(inv, f, s);
    @(posedge clk);
    #1;
    check(name, shf_res, req);
  endtask

  logic [97:0] lit;

  initial begin
    rst_n    = 1'b0;
    inv_mask = 1'b1;
    c_frac   = 24'hFFFFFF;
    shf_num  = 7'd0;
    #2;
    check("reset_state", shf_res, 98'b0);
    @(posedge clk);
    #1;
    check("reset_held_over_edge", shf_res, 98'b0);
    @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Hand-computed vectors that pin the model.
    apply_check("inv0_shf0",   1'b0, 24'hFFFFFF, 7'd0,   {24'hFFFFFF, 74'b0});
    apply_check("inv0_shf10",  1'b0, 24'hFFFFFF, 7'd10,  {10'b0, 24'hFFFFFF, 64'b0});
    apply_check("inv0_shf74",  1'b0, 24'hFFFFFF, 7'd74,  {74'b0, 24'hFFFFFF});
    apply_check("inv1_shf0",   1'b1, 24'hFFFFFF, 7'd0,   {24'b0, {74{1'b1}}});
    apply_check("inv1_shf74",  1'b1, 24'hFFFFFF, 7'd74,  {{74{1'b1}}, 24'b0});
    apply_check("clamp_75",    1'b0, 24'hFFFFFF, 7'd75,  {74'b0, 24'hFFFFFF});
    apply_check("clamp_127",   1'b0, 24'hFFFFFF, 7'd127, {74'b0, 24'hFFFFFF});
    lit = (98'd1 << 24) | (98'd1 << 1);
    apply_check("frac800001_shf73", 1'b0, 24'h800001, 7'd73, lit);
    lit = ~((98'd1 << 24) | (98'd1 << 1));
    apply_check("frac800001_shf73_inv", 1'b1, 24'h800001, 7'd73, lit);
    apply_check("inv1_shf127", 1'b1, 24'hFFFFFF, 7'd127, {{74{1'b1}}, 24'b0});

    // Sweep both polarities; popcount must be 24 or 74 regardless of shift.
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k <= 74; k++) begin
        apply(p[0], 24'hFFFFFF, 7'(k));
        @(posedge clk);
        #1;
        checks++;
        if ($countones(shf_res) != ((p == 0) ? 24 : 74)) begin
          errors++;
          $display("FAIL popcount inv=%0d shf=%0d: got %0d expected %0d",
                   p, k, $countones(shf_res), (p == 0) ? 24 : 74);
        end
        // Async reset mid-sweep, well away from any clock edge.
        if (p == 1 && k == 40) begin
          #2;
          rst_n = 1'b0;
          #1;
          check("async_reset_immediate", shf_res, 98'b0);
          @(posedge clk);
          #1;
          check("async_reset_held", shf_res, 98'b0);
          @(negedge clk);
          rst_n = 1'b1;
          @(posedge clk);
          #1;
          check("first_edge_after_reset", shf_res, {{40{1'b1}}, 24'b0, {34{1'b1}}});
        end
      end
    end

    // Random significands and shift amounts, including the clamp range.
    for (int i = 0; i < 60; i++) begin
      apply(1'($urandom_range(0, 1)), 24'($urandom) | 24'h800000,
            7'($urandom_range(0, 127)));
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    cmp_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
